// File: rtl/ram_rr_scheduler.sv
// ram_rr_scheduler
//   Shares one single-port RAM between N requesters with round-robin
//   arbitration, an optional per-requester lock for bounded bursts, a
//   registered RAM command port and a tag pipeline that routes each read
//   return back to the requester that issued it.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_i/we_i/lock_i    per-requester request, write enable, keep-ownership
//   addr_i/data_i        per-requester address / write data, packed k*W +: W
//   gnt_o                combinational one-hot grant (accepted at this edge)
//   rvalid_o, rdata_o    registered one-hot read-return tag and read data
//   ram_cs_o, ram_we_o   registered RAM chip select / write enable
//   ram_addr_o           registered RAM address
//   ram_data_o           registered RAM write data
//   ram_data_i           RAM read data, valid the cycle after a read command
//   dbg_state_o          1 while a locked owner holds the RAM
//
// Handshake: requester k holds req_i[k], we_i[k], lock_i[k], addr_i and
// data_i stable until gnt_o[k] is high at a rising edge; that edge
// transfers the access. There is no back-pressure on read returns:
// rvalid_o is a one-cycle pulse the requester must take.
module ram_rr_scheduler #(
  parameter int N         = 4,
  parameter int AW        = 9,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    we_i,
  input  logic [N-1:0]    lock_i,
  input  logic [N*AW-1:0] addr_i,
  input  logic [N*DW-1:0] data_i,
  output logic [N-1:0]    gnt_o,
  output logic [N-1:0]    rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            ram_cs_o,
  output logic            ram_we_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic [DW-1:0]   ram_data_o,
  input  logic [DW-1:0]   ram_data_i,
  output logic            dbg_state_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_ARB   = 1'b0,  // open round-robin arbitration from ptr
    ST_OWNED = 1'b1   // a locked owner holds the RAM
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [7:0]    burst_cnt, burst_cnt_n;

  logic [N-1:0]  gnt_raw;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [PW-1:0] gnt_idx_inc;
  logic [PW-1:0] owner_inc;
  logic [PW-1:0] cand;
  int            scan_j;

  // Tag pipeline: s1 lines up with the RAM command, s2 with ram_data_i.
  logic [N-1:0]  tag_s1, tag_s2;

  // Arbitration: only the owner may win while one is held.
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan_j  = 0;
    cand    = '0;
    if (state == ST_OWNED) begin
      if (req_i[owner]) begin
        gnt_raw[owner] = 1'b1;
        gnt_idx        = owner;
        gnt_any        = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        scan_j = (int'(ptr) + i) % N;
        cand   = PW'(scan_j);
        if (!gnt_any && req_i[cand]) begin
          gnt_raw[cand] = 1'b1;
          gnt_idx       = cand;
          gnt_any       = 1'b1;
        end
      end
    end
  end

  // Grants are suppressed while reset is asserted, whatever req_i does.
  assign gnt_o       = rst_n ? gnt_raw : '0;
  assign dbg_state_o = (state == ST_OWNED);

  assign gnt_idx_inc = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  assign owner_inc   = (owner   == PW'(N - 1)) ? '0 : owner + 1'b1;

  // Ownership / pointer next state.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    owner_n     = owner;
    burst_cnt_n = burst_cnt;
    if (gnt_any) begin
      ptr_n = gnt_idx_inc;
      if (state == ST_OWNED) begin
        // Release on an unlocked grant or when this grant hits the cap.
        if (!lock_i[gnt_idx] || (int'(burst_cnt) + 1 >= MAX_BURST)) begin
          state_n     = ST_ARB;
          burst_cnt_n = '0;
        end else begin
          burst_cnt_n = burst_cnt + 8'd1;
        end
      end else if (lock_i[gnt_idx] && (MAX_BURST > 1)) begin
        // With MAX_BURST == 1 the first grant already reaches the cap.
        state_n     = ST_OWNED;
        owner_n     = gnt_idx;
        burst_cnt_n = 8'd1;
      end
    end else if ((state == ST_OWNED) && !lock_i[owner]) begin
      state_n     = ST_ARB;
      burst_cnt_n = '0;
      ptr_n       = owner_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  // Registered RAM command and read-return path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      tag_s1     <= '0;
      tag_s2     <= '0;
      rvalid_o   <= '0;
      rdata_o    <= '0;
    end else begin
      ram_cs_o <= gnt_any;
      if (gnt_any) begin
        ram_we_o   <= we_i[gnt_idx];
        ram_addr_o <= addr_i[gnt_idx*AW +: AW];
        ram_data_o <= data_i[gnt_idx*DW +: DW];
      end else begin
        ram_we_o <= 1'b0;
      end
      tag_s1   <= (gnt_any && !we_i[gnt_idx]) ? gnt_raw : '0;
      tag_s2   <= tag_s1;
      rvalid_o <= tag_s2;
      if (|tag_s2) begin
        rdata_o <= ram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_rr_scheduler.sv
// Directed testbench for ram_rr_scheduler: per-port request queues drive the
// DUT, a small behavioural arbiter and a reference memory predict grants,
// RAM commands and read returns, and hand-written grant tables cover
// fairness, burst cap and post-reset ordering.
module tb_ram_rr_scheduler;
  localparam int N = 4, AW = 9, DW = 32, MAX_BURST = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_i  = '0;
  logic [N-1:0]    we_i   = '0;
  logic [N-1:0]    lock_i = '0;
  logic [N*AW-1:0] addr_i = '0;
  logic [N*DW-1:0] data_i = '0;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o, ram_data_o, ram_data_i;
  logic            ram_cs_o, ram_we_o, dbg_state_o;
  logic [AW-1:0]   ram_addr_o;

  ram_rr_scheduler #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .addr_i(addr_i), .data_i(data_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // RAM macro model: read data appears the cycle after a read command.
  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] ref_mem [0:511];
  always @(posedge clk) begin
    if (ram_cs_o) begin
      if (ram_we_o) mem[ram_addr_o] = ram_data_o;
      else          ram_data_i <= mem[ram_addr_o];
    end
  end

  // ---------------- request queues ----------------
  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;
  acc_t pq [N][0:31];
  int   ph [N];
  int   pt [N];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  tag_q[$];
  int            due_q[$];
  logic [N-1:0]  gnt_log[$];
  logic [N-1:0]  exp_log[$];
  logic [N-1:0]  last_tag;
  logic [DW-1:0] last_data;
  int            cyc;
  int            n_checks = 0;
  int            n_pass   = 0;

  // Arbiter reference state
  int m_ptr, m_own, m_cnt;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int k;
    g = '0;
    if (m_own >= 0) begin
      if (req_i[m_own]) g[m_own] = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (g == '0 && req_i[k]) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [N-1:0] g);
    int k;
    if (g != '0) begin
      k = idx_of(g);
      if (m_own >= 0) begin
        m_cnt++;
        if (!lock_i[k] || m_cnt >= MAX_BURST) begin
          m_own = -1; m_cnt = 0; m_ptr = (k + 1) % N;
        end
      end else begin
        m_ptr = (k + 1) % N;
        if (lock_i[k] && MAX_BURST > 1) begin
          m_own = k; m_cnt = 1;
        end
      end
    end else if (m_own >= 0 && !lock_i[m_own]) begin
      m_ptr = (m_own + 1) % N; m_own = -1; m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_own = -1; m_cnt = 0;
    exp_q.delete(); tag_q.delete(); due_q.delete();
    for (int k = 0; k < N; k++) begin ph[k] = 0; pt[k] = 0; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_acc(input int k, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    pq[k][pt[k]] = '{we: w, lock: l, addr: a, data: d};
    pt[k]++;
  endtask

  function automatic logic busy();
    logic b;
    b = 1'b0;
    for (int k = 0; k < N; k++) if (ph[k] < pt[k]) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    acc_t a;
    for (int k = 0; k < N; k++) begin
      if (ph[k] < pt[k]) begin
        a = pq[k][ph[k]];
        req_i[k]  = 1'b1;
        we_i[k]   = a.we;
        lock_i[k] = a.lock;
        addr_i[k*AW +: AW] = a.addr;
        data_i[k*DW +: DW] = a.data;
      end else begin
        req_i[k]  = 1'b0;
        we_i[k]   = 1'b0;
        lock_i[k] = 1'b0;
      end
    end
  endtask

  // One clock: entered and left just after a falling edge.
  task automatic cycle();
    logic [N-1:0] eg, exp_tag;
    logic         exp_we;
    acc_t         a;
    int           k;
    a = '0;
    drive();
    #1;
    eg = model_gnt();
    check("gnt", 32'(gnt_o), 32'(eg));
    if (gnt_o != '0) gnt_log.push_back(gnt_o);
    @(posedge clk);
    cyc++;
    exp_we = 1'b0;
    if (eg != '0) begin
      k = idx_of(eg);
      a = pq[k][ph[k]];
      ph[k]++;
      exp_we = a.we;
      if (a.we) ref_mem[a.addr] = a.data;
      else begin
        exp_q.push_back(ref_mem[a.addr]);
        tag_q.push_back(eg);
        due_q.push_back(cyc + 2);
      end
    end
    model_update(eg);
    #1;
    check("ram_cs", 32'(ram_cs_o), 32'(eg != '0));
    check("ram_we", 32'(ram_we_o), 32'(exp_we));
    if (eg != '0) begin
      check("ram_addr", 32'(ram_addr_o), 32'(a.addr));
      check("ram_data", ram_data_o, a.data);
    end
    exp_tag = (due_q.size() > 0 && due_q[0] == cyc) ? tag_q[0] : '0;
    check("rvalid", 32'(rvalid_o), 32'(exp_tag));
    if (rvalid_o != '0) begin last_tag = rvalid_o; last_data = rdata_o; end
    if (exp_tag != '0) begin
      check("rdata", rdata_o, exp_q[0]);
      void'(exp_q.pop_front()); void'(tag_q.pop_front()); void'(due_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((busy() || due_q.size() != 0 || m_own >= 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n >= budget), 32'd0);
  endtask

  task automatic reset_checks();
    check("rst_gnt",      32'(gnt_o),      32'd0);
    check("rst_rvalid",   32'(rvalid_o),   32'd0);
    check("rst_rdata",    rdata_o,         32'd0);
    check("rst_cs",       32'(ram_cs_o),   32'd0);
    check("rst_we",       32'(ram_we_o),   32'd0);
    check("rst_ram_addr", 32'(ram_addr_o), 32'd0);
    check("rst_ram_data", ram_data_o,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] lk0, lk3;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    model_reset();
    cyc = 0; last_tag = '0; last_data = '0;

    // Reset held with random requests: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_i  = N'($urandom_range(1, (1 << N) - 1));
      lock_i = N'($urandom_range(0, (1 << N) - 1));
      we_i   = N'($urandom_range(0, (1 << N) - 1));
      #1;
      reset_checks();
    end
    @(negedge clk);
    req_i = '0; lock_i = '0; we_i = '0;
    rst_n = 1'b1;

    // Fairness: all ports write continuously, no locks.
    gnt_log.delete();
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < N; k++)
        push_acc(k, 1'b1, 1'b0, AW'(9'h100 + k * 8 + i), 32'hF000_0000 + 32'(k * 256 + i));
    run(200);
    check("fair_len", 32'(gnt_log.size()), 32'd24);
    for (int i = 0; i < 24; i++) check("fair_seq", 32'(gnt_log[i]), 32'(1 << (i % 4)));

    // Read latency: port 1 reads 0x045.
    last_tag = '0; last_data = '0;
    push_acc(1, 1'b0, 1'b0, 9'h045, 32'd0);
    run(50);
    check("rd_tag",  32'(last_tag), 32'h0000_0002);
    check("rd_data", last_data,     32'hC0DE_0045);

    // Burst cap: port 2 locks 12 reads, port 0 joins one cycle later.
    gnt_log.delete();
    for (int i = 0; i < 12; i++) push_acc(2, 1'b0, 1'b1, AW'(9'h010 + i), 32'd0);
    cycle();
    for (int i = 0; i < 6; i++) push_acc(0, 1'b1, 1'b0, AW'(9'h180 + i), 32'h5500_0000 + 32'(i));
    run(200);
    exp_log.delete();
    for (int i = 0; i < 8; i++) exp_log.push_back(4'b0100);
    exp_log.push_back(4'b0001);
    for (int i = 0; i < 4; i++) exp_log.push_back(4'b0100);
    for (int i = 0; i < 5; i++) exp_log.push_back(4'b0001);
    check("burst_len", 32'(gnt_log.size()), 32'd18);
    for (int i = 0; i < 18; i++) check("burst_seq", 32'(gnt_log[i]), 32'(exp_log[i]));

    // Mixed traffic: ports 0 and 3 alternate write/read with a fixed lock pattern.
    lk0 = 8'b1011_0010;
    lk3 = 8'b0110_1101;
    for (int i = 0; i < 8; i++) begin
      push_acc(0, (i % 2 == 0), lk0[i], AW'(9'h020 + i / 2), 32'h0A00_0000 + 32'(i));
      push_acc(3, (i % 2 == 0), lk3[i], AW'(9'h030 + i / 2), 32'h3A00_0000 + 32'(i));
    end
    run(300);
    check("mix_pending", 32'(exp_q.size()), 32'd0);

    // Reset during reads: two reads granted, then reset for one cycle.
    push_acc(1, 1'b0, 1'b0, 9'h045, 32'd0);
    push_acc(1, 1'b0, 1'b0, 9'h046, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b0;
    model_reset();
    drive();
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    last_tag = '0;
    for (int i = 0; i < 4; i++) cycle();
    for (int k = N - 1; k >= 0; k--) push_acc(k, 1'b1, 1'b0, AW'(9'h1F0 + k), 32'h7700_0000 + 32'(k));
    run(50);
    check("post_rst_first", 32'(gnt_log[0]), 32'h0000_0001);
    check("post_rst_no_rv", 32'(last_tag), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
